// File: rtl/sipo_deserializer_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer.
package sipo_pkg;

  localparam int BIT_ORDER_MSB = 1;
  localparam int BIT_ORDER_LSB = 0;

  // A one-bit counter is still needed when $clog2 would return 0.
  function automatic int clog2_min1(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, word output and handshake bundle for sipo_deserializer.
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  localparam int CNT_W = clog2_min1(WIDTH);

  logic             sin;
  logic             sin_valid;
  logic             clear;
  logic [WIDTH-1:0] pdata;
  logic             pvalid;
  logic             pready;
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;

  // master: the environment feeding bits and consuming words.
  modport master (
    output sin, sin_valid, clear, pready,
    input  pdata, pvalid, overrun, bit_cnt
  );

  modport slave (
    input  sin, sin_valid, clear, pready,
    output pdata, pvalid, overrun, bit_cnt
  );

endinterface

// File: rtl/sipo_deserializer_shift_core.sv
// Shift register and bit counter; pulses done with the completed word
// on the edge that accepts the last bit.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = BIT_ORDER_MSB,
  parameter int CNT_W     = clog2_min1(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;

  generate
    if (MSB_FIRST != BIT_ORDER_LSB) begin : g_msb
      assign shifted = {sr_q[WIDTH-2:0], sin};
    end else begin : g_lsb
      assign shifted = {sin, sr_q[WIDTH-1:1]};
    end
  endgenerate

  // word is only meaningful while done is high; it includes the incoming bit.
  assign word    = shifted;
  assign bit_cnt = cnt_q;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    done  = 1'b0;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (sin_valid) begin
      sr_d = shifted;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out converter: holding register, valid/ready hand-off
// and sticky overrun around the shift core.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = BIT_ORDER_MSB
) (
  input  logic                clk,
  input  logic                rst_,
  sipo_deserializer_if.slave  bus
);

  localparam int CNT_W = clog2_min1(WIDTH);

  logic [WIDTH-1:0] word;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;

  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             pvalid_q, pvalid_d;
  logic             overrun_q, overrun_d;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst_      (rst_),
    .sin       (bus.sin),
    .sin_valid (bus.sin_valid),
    .clear     (bus.clear),
    .word      (word),
    .done      (done),
    .bit_cnt   (bit_cnt)
  );

  // clear suppresses done in the core, so it never races a load here.
  always_comb begin
    pdata_d   = pdata_q;
    pvalid_d  = pvalid_q;
    overrun_d = overrun_q;
    if (pvalid_q && bus.pready) begin
      pvalid_d = 1'b0;
    end
    if (done) begin
      if (!pvalid_q || bus.pready) begin
        pdata_d  = word;
        pvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (bus.clear) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pdata_q   <= '0;
      pvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pdata_q   <= pdata_d;
      pvalid_q  <= pvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.pdata   = pdata_q;
  assign bus.pvalid  = pvalid_q;
  assign bus.overrun = overrun_q;
  assign bus.bit_cnt = bit_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Drives one stimulus stream into an MSB-first and an LSB-first deserializer
// and checks both against a word-level model.
module tb_sipo_deserializer;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic sin = 1'b0, sin_valid = 1'b0, clear = 1'b0, pready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the current partial word, in arrival order.
  bit       bits[$];
  logic [7:0] pd_m = '0, pd_l = '0;
  logic       pv_m = 1'b0, ov_m = 1'b0;

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(8)) if_m ();
  sipo_deserializer_if #(.WIDTH(8)) if_l ();

  assign if_m.sin = sin;  assign if_m.sin_valid = sin_valid;
  assign if_m.clear = clear;  assign if_m.pready = pready;
  assign if_l.sin = sin;  assign if_l.sin_valid = sin_valid;
  assign if_l.clear = clear;  assign if_l.pready = pready;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (.clk(clk), .rst_(rst_), .bus(if_m.slave));
  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (.clk(clk), .rst_(rst_), .bus(if_l.slave));

  function automatic logic [7:0] assemble(input bit msb);
    logic [7:0] w = '0;
    for (int i = 0; i < 8; i++) begin
      if (msb) w[7 - i] = bits[i];
      else     w[i]     = bits[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    bits.delete();
    pd_m = '0; pd_l = '0; pv_m = 1'b0; ov_m = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic v, input logic c, input logic r);
    bit completed = 0;
    logic [7:0] wm = '0, wl = '0;
    logic pv_new;
    if (c) begin
      bits.delete();
      ov_m = 1'b0;
    end else if (v) begin
      bits.push_back(s);
      if (bits.size() == 8) begin
        completed = 1;
        wm = assemble(1);
        wl = assemble(0);
        bits.delete();
      end
    end
    pv_new = pv_m && !r;
    if (completed) begin
      if (!pv_m || r) begin
        pd_m = wm; pd_l = wl; pv_new = 1'b1;
      end else begin
        ov_m = 1'b1;
      end
    end
    pv_m = pv_new;
  endtask

  task automatic step(input logic s, input logic v, input logic c, input logic r);
    sin = s; sin_valid = v; clear = c; pready = r;
    @(posedge clk);
    model_edge(s, v, c, r);
    #1;
  endtask

  // Sends w MSB-first on the wire; pready is held at r except on the last bit.
  task automatic send_word(input logic [7:0] w, input logic r, input logic r_last);
    for (int i = 7; i >= 0; i--) step(w[i], 1'b1, 1'b0, (i == 0) ? r_last : r);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({if_m.pdata, if_l.pdata, if_m.pvalid, if_l.pvalid, if_m.overrun, if_l.overrun,
         if_m.bit_cnt, if_l.bit_cnt} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state pdata %h/%h pvalid %b/%b overrun %b/%b bit_cnt %0d/%0d required all 0",
               if_m.pdata, if_l.pdata, if_m.pvalid, if_l.pvalid, if_m.overrun, if_l.overrun,
               if_m.bit_cnt, if_l.bit_cnt);
    end
    #11 rst_ = 1'b1;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [7:0] pat = 8'b1011_0100;
    for (int i = 7; i >= 0; i--) begin
      checks++;
      if (if_m.bit_cnt !== 3'(7 - i) || if_l.bit_cnt !== 3'(7 - i)) begin
        errors++;
        $display("FAIL stream_bit_cnt got %0d/%0d required %0d", if_m.bit_cnt, if_l.bit_cnt, 7 - i);
      end
      step(pat[i], 1'b1, 1'b0, 1'b1);
    end
    checks++;
    if (if_m.pdata !== 8'hB4 || if_l.pdata !== 8'h2D || if_m.pvalid !== 1'b1 ||
        if_l.pvalid !== 1'b1 || if_m.bit_cnt !== 3'd0 || if_l.bit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL stream_word pdata %h/%h pvalid %b/%b cnt %0d/%0d required b4/2d 1/1 0/0",
               if_m.pdata, if_l.pdata, if_m.pvalid, if_l.pvalid, if_m.bit_cnt, if_l.bit_cnt);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (if_m.pvalid !== 1'b0 || if_l.pvalid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain pvalid %b/%b required 0", if_m.pvalid, if_l.pvalid);
    end
    $display("test_stream done words b4/2d");
  endtask

  task automatic test_overrun();
    send_word(8'hB4, 1'b0, 1'b0);
    send_word(8'h11, 1'b0, 1'b0);
    checks++;
    if (if_m.pdata !== 8'hB4 || if_l.pdata !== pd_l || if_m.pvalid !== 1'b1 ||
        if_m.overrun !== 1'b1 || if_l.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set pdata %h/%h pvalid %b overrun %b/%b required b4/%h 1 1/1",
               if_m.pdata, if_l.pdata, if_m.pvalid, if_m.overrun, if_l.overrun, pd_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (if_m.pvalid !== 1'b0 || if_m.overrun !== 1'b1 || if_l.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky pvalid %b overrun %b/%b required 0 1/1",
               if_m.pvalid, if_m.overrun, if_l.overrun);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (if_m.overrun !== 1'b0 || if_l.overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear overrun %b/%b required 0", if_m.overrun, if_l.overrun);
    end
    $display("test_overrun done");
  endtask

  task automatic test_back_to_back();
    send_word(8'hB4, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b1);
    checks++;
    if (if_m.pdata !== 8'h5A || if_l.pdata !== pd_l || if_m.pvalid !== 1'b1 ||
        if_m.overrun !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_handoff pdata %h/%h pvalid %b overrun %b required 5a/%h 1 0",
               if_m.pdata, if_l.pdata, if_m.pvalid, if_m.overrun, pd_l);
    end
    for (int w = 0; w < 4; w++) begin
      logic [7:0] v = 8'($urandom);
      send_word(v, 1'b1, 1'b1);
      checks++;
      if (if_m.pdata !== v || if_l.pdata !== pd_l || if_m.pvalid !== 1'b1 || if_m.overrun !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back pdata %h/%h pvalid %b overrun %b required %h/%h 1 0",
                 if_m.pdata, if_l.pdata, if_m.pvalid, if_m.overrun, v, pd_l);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    $display("test_back_to_back done");
  endtask

  task automatic test_clear_midword();
    logic [7:0] v = 8'($urandom);
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (if_m.bit_cnt !== 3'd0 || if_l.bit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL clear_bit_cnt got %0d/%0d required 0", if_m.bit_cnt, if_l.bit_cnt);
    end
    send_word(v, 1'b1, 1'b1);
    checks++;
    if (if_m.pdata !== v || if_l.pdata !== pd_l || if_m.pvalid !== 1'b1) begin
      errors++;
      $display("FAIL clear_next_word pdata %h/%h pvalid %b required %h/%h 1",
               if_m.pdata, if_l.pdata, if_m.pvalid, v, pd_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    $display("test_clear_midword done word %h", v);
  endtask

  task automatic test_async_reset();
    logic [7:0] v = 8'($urandom);
    send_word(8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    sin_valid = 1'b0;
    #2 rst_ = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({if_m.pdata, if_l.pdata, if_m.pvalid, if_l.pvalid, if_m.overrun, if_l.overrun,
         if_m.bit_cnt, if_l.bit_cnt} !== 24'h0) begin
      errors++;
      $display("FAIL async_reset pdata %h/%h pvalid %b/%b overrun %b/%b bit_cnt %0d/%0d required all 0",
               if_m.pdata, if_l.pdata, if_m.pvalid, if_l.pvalid, if_m.overrun, if_l.overrun,
               if_m.bit_cnt, if_l.bit_cnt);
    end
    @(posedge clk); @(posedge clk);
    #3 rst_ = 1'b1;
    @(posedge clk); #1;
    send_word(v, 1'b1, 1'b1);
    checks++;
    if (if_m.pdata !== v || if_l.pdata !== pd_l || if_m.pvalid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_word pdata %h/%h pvalid %b required %h/%h 1",
               if_m.pdata, if_l.pdata, if_m.pvalid, v, pd_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    $display("test_async_reset done word %h", v);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(31) == 0), 1'($urandom));
      checks++;
      if (if_m.pdata !== pd_m || if_l.pdata !== pd_l || if_m.pvalid !== pv_m ||
          if_l.pvalid !== pv_m || if_m.overrun !== ov_m || if_l.overrun !== ov_m ||
          if_m.bit_cnt !== 3'(bits.size()) || if_l.bit_cnt !== 3'(bits.size())) begin
        errors++;
        $display("FAIL random_%0d pdata %h/%h pv %b/%b ov %b/%b cnt %0d/%0d required %h/%h %b %b %0d",
                 n, if_m.pdata, if_l.pdata, if_m.pvalid, if_l.pvalid, if_m.overrun, if_l.overrun,
                 if_m.bit_cnt, if_l.bit_cnt, pd_m, pd_l, pv_m, ov_m, bits.size());
      end
    end
    $display("test_random done 400 cycles");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overrun();
    test_back_to_back();
    test_clear_midword();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Parametrised serial-in/parallel-out converter that assembles WIDTH-bit words from a qualified serial bit stream. Bit order is selectable. Completed words are held in an output register and handed off over a valid/ready handshake, with sticky overrun detection. Sits between serial receive front-ends (bit-level links, sensor interfaces) and word-oriented consumers.

Parameters:
WIDTH, 8, word width in bits; legal range 2..64.
MSB_FIRST, 1, 1: first received bit lands in pdata[WIDTH-1]; 0: first received bit lands in pdata[0].
CNT_W, $clog2(WIDTH), width of bit_cnt; derived, do not override.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst_  input  1  asynchronous, active-low reset.
sin  input  1  serial data bit.
sin_valid  input  1  sin is sampled on a clk edge only when high.
clear  input  1  synchronous frame restart; discards the partial word and clears overrun.
pdata  output  WIDTH  last completed word (holding register).
pvalid  output  1  pdata holds an unconsumed word.
pready  input  1  consumer accepts pdata when pvalid && pready at a clk edge.
overrun  output  1  sticky; a completed word was dropped.
bit_cnt  output  CNT_W  bits accepted into the current partial word, 0..WIDTH-1.

Behaviour:
- Reset (rst_ low, asynchronous, any time incl. mid-word): shift register = 0, bit_cnt = 0, pdata = 0, pvalid = 0, overrun = 0. The first word after reset release starts at bit 0.
- Shift, MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}. MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
- Accept: on each edge with sin_valid=1 and clear=0, shift sin in and increment bit_cnt.
- Completion: when a bit is accepted with bit_cnt == WIDTH-1:
  - the completed word (sr including this bit) is formed;
  - bit_cnt wraps to 0;
  - sr is not required to be cleared.
- Load rule at completion:
  - if pvalid=0, or pvalid=1 && pready=1 in the same cycle: pdata <= word, pvalid <= 1;
  - if pvalid=1 && pready=0: word is dropped, pdata is unchanged, overrun <= 1.
- Latency: pdata and pvalid are visible after the same edge that accepts the last bit. This is 0 extra cycles of latency; a full word takes WIDTH accepted bits.
- Handshake:
  - pvalid stays high and pdata stays stable until an edge with pready=1;
  - on that edge pvalid falls unless a new word completes on the same edge, in which case pvalid stays high.
  - pready while pvalid=0 has no effect.
- sin_valid=0: no shift and no count change. Gaps of any length are allowed mid-word.
- clear=1:
  - bit_cnt <= 0, sr <= 0, overrun <= 0;
  - any sin_valid bit on the same edge is discarded (clear wins), so no completion can occur on that edge;
  - pdata and pvalid are unaffected, and a handshake on the same edge still completes normally.
- overrun: set only by a dropped word. Cleared only by clear or reset. Remains set across further words.
- Back-to-back: continuous sin_valid=1 with pready=1 yields one word every WIDTH cycles with no loss.

Decomposition:
- Shared package sipo_pkg holds:
  - localparams BIT_ORDER_MSB=1 and BIT_ORDER_LSB=0;
  - a helper function clog2_min1 that returns at least 1, for CNT_W.
- One natural sub-module, sipo_shift_core: the shift register plus bit counter, emitting word and done pulse, parametrised by WIDTH/MSB_FIRST.
- The top level adds the holding register, handshake and overrun logic.

Test Plan:
- WIDTH=8, MSB_FIRST=1, pready=1, stream 1,0,1,1,0,1,0,0 on consecutive edges -> pdata=8'hB4 and pvalid=1 after the 8th edge; pvalid=0 one edge later.
- MSB_FIRST=0, same stream -> pdata=8'h2D; bit_cnt steps 0..7 and then reads 0 after the 8th bit.
- pready=0, send two full words 8'hB4 then 8'h11 -> pdata stays 8'hB4, pvalid=1, overrun=1 after the 16th bit. Then pready=1 for one edge -> pvalid=0 with overrun still 1. Then clear -> overrun=0.
- pvalid=1 holding 8'hB4, pready=1 asserted on the same edge the next word 8'h5A completes -> pdata=8'h5A, pvalid stays 1, overrun=0.
- Clear mid-word: 5 bits sent, clear=1 with sin_valid=1 on the same edge -> bit_cnt=0, that bit is dropped. The next 8 bits form a clean word matching the expected value.
- Drop rst_ after 3 bits of a word (asynchronously, between edges) -> all outputs read 0 immediately. After release, the 8 new bits give the correct word, with no stale bits.
